// File: rtl/spi_mm_pkg.sv
// Shared types and constants for the multi-channel SPI master.
// State encoding, default parameter values and the request-length width helper.
package spi_mm_pkg;

    localparam int DEF_NCHAN  = 4;
    localparam int DEF_DWIDTH = 32;
    localparam int DEF_DIVW   = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT,
        ST_HOLD,
        ST_GAP,
        ST_DONE
    } state_e;

    // Width of a bit-count field able to hold 0..dwidth
    function automatic int len_width(input int dwidth);
        return $clog2(dwidth + 1);
    endfunction

endpackage

// File: rtl/spi_mm_tick.sv
// Half-period strobe generator: pulses every (div+1) cycles, restarted from zero
// while restart is high so each timed state begins with a full half-period.
module spi_mm_tick
    import spi_mm_pkg::*;
#(
    parameter int DIVW = DEF_DIVW
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            restart,
    input  logic [DIVW-1:0] div,
    output logic            tick
);

    logic [DIVW-1:0] cnt_q, cnt_d;

    assign tick = !restart && (cnt_q == div);

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (restart || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/spi_multi_master.sv
// Multi-channel SPI master (CPHA=0, per-channel CPOL) with one shared SCLK/MOSI.
// Define SPI_MULTI_MASTER_READBACK_EN to sample MISO into rsp_rdata; otherwise rsp_rdata is 0.
module spi_multi_master
    import spi_mm_pkg::*;
#(
    parameter int NCHAN  = DEF_NCHAN,
    parameter int DWIDTH = DEF_DWIDTH,
    parameter int DIVW   = DEF_DIVW
) (
    input  logic                           sys0Clk,
    input  logic                           sys0Rst,
    input  logic [DIVW-1:0]                cfg_div,
    input  logic [NCHAN-1:0]               cfg_cpol,
    input  logic                           req_valid,
    output logic                           req_ready,
    input  logic [3:0]                     req_chan,
    input  logic [len_width(DWIDTH)-1:0]   req_len,
    input  logic [DWIDTH-1:0]              req_wdata,
    output logic                           rsp_valid,
    input  logic                           rsp_ready,
    output logic [DWIDTH-1:0]              rsp_rdata,
    output logic                           rsp_err,
    output logic                           spi_sclk,
    output logic                           spi_mosi,
    output logic [NCHAN-1:0]               spi_sen,
    input  logic [NCHAN-1:0]               spi_miso
);

    localparam int              LW      = len_width(DWIDTH);
    localparam logic [LW-1:0]   LEN_MAX = LW'(DWIDTH);

    state_e            state_q, state_d;
    logic [3:0]        chan_q, chan_d;
    logic [LW-1:0]     bits_q, bits_d;
    logic              half_q, half_d;
    logic [DWIDTH-1:0] shreg_q, shreg_d;
    logic              sclk_q, sclk_d;
    logic [NCHAN-1:0]  sen_q, sen_d;
    logic              ready_q, ready_d;
    logic              valid_q, valid_d;
    logic              err_q, err_d;
    logic              tick, restart, accept, lead_edge, active_d;
    logic              cpol_req, cpol_cur;

    function automatic logic pick(input logic [NCHAN-1:0] vec, input logic [3:0] idx);
        logic r;
        r = 1'b0;
        for (int i = 0; i < NCHAN; i++) begin
            if (idx == 4'(i)) begin
                r = vec[i];
            end
        end
        return r;
    endfunction

    assign cpol_req = pick(cfg_cpol, req_chan);
    assign cpol_cur = pick(cfg_cpol, chan_q);

    // Every timed state exits on a tick, which also zeroes the counter
    assign restart = (state_q == ST_IDLE) || (state_q == ST_DONE);

    spi_mm_tick #(.DIVW(DIVW)) u_tick (
        .clk     (sys0Clk),
        .rst_n   (sys0Rst),
        .restart (restart),
        .div     (cfg_div),
        .tick    (tick)
    );

    always_comb begin
        state_d   = state_q;
        chan_d    = chan_q;
        bits_d    = bits_q;
        half_d    = half_q;
        shreg_d   = shreg_q;
        sclk_d    = sclk_q;
        err_d     = err_q;
        accept    = 1'b0;
        lead_edge = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_valid && ready_q) begin
                    accept  = 1'b1;
                    state_d = ST_SETUP;
                    chan_d  = req_chan;
                    shreg_d = req_wdata;
                    half_d  = 1'b0;
                    err_d   = (int'(req_chan) >= NCHAN);
                    bits_d  = (req_len == '0 || req_len > LEN_MAX) ? LEN_MAX : req_len;
                    sclk_d  = (int'(req_chan) >= NCHAN) ? 1'b0 : cpol_req;
                end
            end
            ST_SETUP: begin
                if (tick) begin
                    state_d   = ST_SHIFT;
                    half_d    = 1'b0;
                    lead_edge = 1'b1;
                    sclk_d    = err_q ? cpol_cur : !cpol_cur;
                end
            end
            ST_SHIFT: begin
                if (tick) begin
                    if (!half_q) begin
                        // Trailing edge: return to idle level and present the next bit
                        sclk_d  = cpol_cur;
                        shreg_d = {shreg_q[DWIDTH-2:0], 1'b0};
                        half_d  = 1'b1;
                    end else if (bits_q == LW'(1)) begin
                        state_d = ST_HOLD;
                    end else begin
                        sclk_d    = err_q ? cpol_cur : !cpol_cur;
                        half_d    = 1'b0;
                        bits_d    = bits_q - LW'(1);
                        lead_edge = 1'b1;
                    end
                end
            end
            ST_HOLD: begin
                if (tick) begin
                    state_d = ST_GAP;
                end
            end
            ST_GAP: begin
                if (tick) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign active_d = (state_d == ST_SETUP) || (state_d == ST_SHIFT) || (state_d == ST_HOLD);
    assign ready_d  = (state_d == ST_IDLE);
    assign valid_d  = (state_d == ST_DONE);

    // An out-of-range channel never matches any index, so all enables stay high
    generate
        for (genvar gi = 0; gi < NCHAN; gi++) begin : g_sen
            assign sen_d[gi] = !(active_d && (chan_d == 4'(gi)));
        end
    endgenerate

    always_ff @(posedge sys0Clk) begin
        if (!sys0Rst) begin
            state_q <= ST_IDLE;
            chan_q  <= '0;
            bits_q  <= '0;
            half_q  <= 1'b0;
            shreg_q <= '0;
            sclk_q  <= 1'b0;
            sen_q   <= '1;
            ready_q <= 1'b0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            chan_q  <= chan_d;
            bits_q  <= bits_d;
            half_q  <= half_d;
            shreg_q <= shreg_d;
            sclk_q  <= sclk_d;
            sen_q   <= sen_d;
            ready_q <= ready_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

`ifdef SPI_MULTI_MASTER_READBACK_EN
    logic [DWIDTH-1:0] rdata_q, rdata_d;
    logic              miso_sel;

    assign miso_sel = pick(spi_miso, chan_q);

    always_comb begin
        rdata_d = rdata_q;
        if (accept) begin
            rdata_d = '0;
        end else if (lead_edge) begin
            rdata_d = {rdata_q[DWIDTH-2:0], miso_sel};
        end
    end

    always_ff @(posedge sys0Clk) begin
        if (!sys0Rst) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rsp_rdata = rdata_q;
`else
    logic unused_readback;
    assign unused_readback = ^{spi_miso, lead_edge, accept};
    assign rsp_rdata       = '0;
`endif

    assign req_ready = ready_q;
    assign rsp_valid = valid_q;
    assign rsp_err   = err_q;
    assign spi_sclk  = sclk_q;
    assign spi_mosi  = shreg_q[DWIDTH-1];
    assign spi_sen   = sen_q;

endmodule

// File: tb/tb_spi_multi_master.sv
// Self-checking bench for spi_multi_master: directed and random transfers scored
// against a per-transaction model built from length, divider and channel rules.
`timescale 1ns/1ps
module tb_spi_multi_master;

    localparam int NCHAN  = 4;
    localparam int DWIDTH = 32;
    localparam int DIVW   = 8;
    localparam int LW     = $clog2(DWIDTH + 1);
`ifdef SPI_MULTI_MASTER_READBACK_EN
    localparam bit RB = 1'b1;
`else
    localparam bit RB = 1'b0;
`endif

    logic              sys0Clk = 1'b0;
    logic              sys0Rst = 1'b0;
    logic [DIVW-1:0]   cfg_div = '0;
    logic [NCHAN-1:0]  cfg_cpol = '0;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic [3:0]        req_chan = '0;
    logic [LW-1:0]     req_len = '0;
    logic [DWIDTH-1:0] req_wdata = '0;
    logic              rsp_valid;
    logic              rsp_ready = 1'b0;
    logic [DWIDTH-1:0] rsp_rdata;
    logic              rsp_err;
    logic              spi_sclk;
    logic              spi_mosi;
    logic [NCHAN-1:0]  spi_sen;
    logic [NCHAN-1:0]  spi_miso;

    int checks = 0;
    int errors = 0;
    int lb_chan = 0;

    always #5 sys0Clk = ~sys0Clk;

    // Target channel loops MOSI back; the others return the inverse so a wrong mux shows up
    always_comb begin
        spi_miso = '0;
        for (int i = 0; i < NCHAN; i++) begin
            spi_miso[i] = (i == lb_chan) ? spi_mosi : ~spi_mosi;
        end
    end

    spi_multi_master #(.NCHAN(NCHAN), .DWIDTH(DWIDTH), .DIVW(DIVW)) dut (
        .sys0Clk   (sys0Clk),
        .sys0Rst   (sys0Rst),
        .cfg_div   (cfg_div),
        .cfg_cpol  (cfg_cpol),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_chan  (req_chan),
        .req_len   (req_len),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .spi_sclk  (spi_sclk),
        .spi_mosi  (spi_mosi),
        .spi_sen   (spi_sen),
        .spi_miso  (spi_miso)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge sys0Clk);
        #1;
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_sen"},   64'(spi_sen),   64'({NCHAN{1'b1}}));
        chk({tag, "_sclk"},  64'(spi_sclk),  64'd0);
        chk({tag, "_mosi"},  64'(spi_mosi),  64'd0);
        chk({tag, "_ready"}, 64'(req_ready), 64'd0);
        chk({tag, "_valid"}, 64'(rsp_valid), 64'd0);
        chk({tag, "_rdata"}, 64'(rsp_rdata), 64'd0);
        chk({tag, "_err"},   64'(rsp_err),   64'd0);
    endtask

    // One transfer: bp = cycles of rsp_ready low in DONE; abort_edge != 0 resets after that leading edge
    task automatic xfer(input int chan, input int len, input logic [31:0] wdata,
                        input int div, input int bp, input int abort_edge);
        int eff, h, lat_exp, cyc, edges, low_cnt, bad_low, rdy_hi, bp_bad;
        logic [63:0] cap, exp_bits, exp_rd;
        logic ok, cp, prev;
        logic [NCHAN-1:0] tgt_mask;

        eff      = (len == 0 || len > DWIDTH) ? DWIDTH : len;
        h        = div + 1;
        lat_exp  = (2 * eff + 3) * h + 1;
        ok       = (chan < NCHAN);
        cp       = ok ? cfg_cpol[chan] : 1'b0;
        exp_bits = 64'(wdata) >> (DWIDTH - eff);
        exp_rd   = (RB && ok) ? exp_bits : 64'd0;
        tgt_mask = ok ? ~(NCHAN'(1) << chan) : {NCHAN{1'b1}};

        lb_chan   = chan;
        cfg_div   = DIVW'(div);
        req_chan  = 4'(chan);
        req_len   = LW'(len);
        req_wdata = wdata;
        req_valid = 1'b1;
        rsp_ready = (bp == 0);

        cyc = 0;
        while (!req_ready && cyc < 50) begin
            step();
            cyc++;
        end
        chk("accept_ready", 64'(req_ready), 64'd1);
        step();
        // Scramble request inputs: the transfer must use the values captured at accept
        req_valid = 1'b0;
        req_chan  = 4'($urandom);
        req_len   = LW'($urandom);
        req_wdata = $urandom;

        cyc = 1; edges = 0; low_cnt = 0; bad_low = 0; rdy_hi = 0; cap = '0; prev = cp;
        chk("setup_sclk", 64'(spi_sclk), 64'(cp));
        while (!rsp_valid && cyc <= lat_exp + 10) begin
            if (ok && spi_sen == tgt_mask) low_cnt++;
            else if (spi_sen != {NCHAN{1'b1}}) bad_low++;
            if (req_ready) rdy_hi++;
            if (spi_sclk != prev && spi_sclk != cp) begin
                edges++;
                cap = {cap[62:0], spi_mosi};
            end
            prev = spi_sclk;
            if (abort_edge != 0 && edges == abort_edge) begin
                sys0Rst = 1'b0;
                step();
                check_reset_values("midreset");
                sys0Rst = 1'b1;
                step();
                chk("midreset_ready_rise", 64'(req_ready), 64'd1);
                chk("midreset_no_rsp", 64'(rsp_valid), 64'd0);
                return;
            end
            step();
            cyc++;
        end

        chk("latency", 64'(cyc), 64'(lat_exp));
        chk("rsp_err", 64'(rsp_err), 64'(!ok));
        chk("rsp_rdata", 64'(rsp_rdata), exp_rd);
        chk("sen_low_cycles", 64'(low_cnt), ok ? 64'((2 * eff + 2) * h) : 64'd0);
        chk("sen_stray", 64'(bad_low), 64'd0);
        chk("ready_while_busy", 64'(rdy_hi), 64'd0);
        if (ok) begin
            chk("sclk_periods", 64'(edges), 64'(eff));
            chk("mosi_bits", cap, exp_bits);
            chk("sclk_idle_done", 64'(spi_sclk), 64'(cp));
        end

        bp_bad = 0;
        for (int i = 0; i < bp; i++) begin
            step();
            if (!(rsp_valid && 64'(rsp_rdata) == exp_rd && rsp_err == !ok && !req_ready)) bp_bad++;
        end
        if (bp > 0) chk("backpressure_stable", 64'(bp_bad), 64'd0);

        rsp_ready = 1'b1;
        step();
        chk("rsp_drop", 64'(rsp_valid), 64'd0);
        chk("ready_after_done", 64'(req_ready), 64'd1);
        rsp_ready = 1'b0;
        $display("xfer chan=%0d len=%0d div=%0d bp=%0d wdata=%08h rdata=%08h err=%0d lat=%0d",
                 chan, len, div, bp, wdata, rsp_rdata, rsp_err, cyc);
    endtask

    initial begin
        sys0Rst = 1'b0;
        repeat (3) step();
        check_reset_values("reset");
        sys0Rst = 1'b1;
        step();
        chk("ready_rise", 64'(req_ready), 64'd1);

        cfg_cpol = '0;
        xfer(1, 16, 32'hA5C3_0000, 1, 0, 0);
        xfer(0, 0, $urandom, 0, 0, 0);
        xfer(3, 40, $urandom, 0, 0, 0);
        xfer(7, 12, $urandom, 1, 0, 0);
        xfer(1, 20, $urandom, 2, 10, 0);
        xfer(0, 16, $urandom, 0, 0, 5);
        xfer(0, 16, $urandom, 0, 0, 0);
        cfg_cpol = 4'b0100;
        xfer(2, 8, $urandom, 1, 0, 0);
        xfer(2, 1, $urandom, 0, 3, 0);

        for (int i = 0; i < 8; i++) begin
            cfg_cpol = NCHAN'($urandom);
            xfer(int'($urandom_range(0, 5)), int'($urandom_range(0, 40)), $urandom,
                 int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
